// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's memory port and the data-memory responder.
interface dmem_responder_if;
  logic        rmem;
  logic        wmem;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_type;
  logic        mem_sign;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        misalign;

  modport master (
    output rmem, wmem, mem_addr, mem_wdata, mem_type, mem_sign,
    input  mem_rdata, busy, misalign
  );

  modport slave (
    input  rmem, wmem, mem_addr, mem_wdata, mem_type, mem_sign,
    output mem_rdata, busy, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state insertion, byte/half/word access, sign/zero-extended loads.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rstn,
  dmem_responder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       rdata_q;
  logic              misalign_q;

  logic              req;
  logic              is_store;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic              access;
  logic              we;
  logic              busy_c;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic              unused_addr;

  logic [31:0] mem [DEPTH];

  // A store wins when both strobes are raised together.
  assign req      = bus.rmem | bus.wmem;
  assign is_store = bus.wmem;
  assign idx      = bus.mem_addr[ADDR_W+1:2];
  assign lane     = bus.mem_addr[1:0];
  assign is_byte  = (bus.mem_type == MT_BYTE);
  assign is_half  = (bus.mem_type == MT_HALF);
  assign is_word  = !is_byte && !is_half;

  assign unused_addr = ^(bus.mem_addr >> (ADDR_W + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign access = (state == ST_WAIT) && req && (cnt == '0);
  assign we     = access && is_store && !misaligned;

  // Lane selection ignores the low address bits a half/word access does not use,
  // which is what forces alignment when the trap is disabled.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    be     = 4'b0000;
    wlanes = bus.mem_wdata;
    if (is_byte) begin
      be[lane] = 1'b1;
      wlanes   = {4{bus.mem_wdata[7:0]}};
    end else if (is_half) begin
      be     = lane[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{bus.mem_wdata[15:0]}};
    end else begin
      be = 4'b1111;
    end
  end

  // NOTE: the array is deliberately left out of reset; only the control path is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[idx];
  assign byte_sel = rd_word[8*lane +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    if (is_byte) begin
      load_val = {{24{bus.mem_sign & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = {{16{bus.mem_sign & half_sel[15]}}, half_sel};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= ST_DONE;
            misalign_q <= misaligned;
            rdata_q    <= (is_store || misaligned) ? 32'h0 : load_val;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The core stalls in the very cycle it raises a request; reset masks the stall.
  always_comb begin
    busy_c = 1'b0;
    case (state)
      ST_IDLE: busy_c = req;
      ST_WAIT: busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
    if (!rstn) busy_c = 1'b0;
  end

  assign bus.busy      = busy_c;
  assign bus.mem_rdata = rdata_q;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected load results queued at issue, compared at DONE.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int MAX_CYC     = 20;

  localparam logic [1:0] T_B = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_W = 2'b10;
  localparam logic [1:0] T_R = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  exp_t sb[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH      (1024),
    .ADDR_W     (10),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] t, input bit s);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (t)
      T_B:     return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      T_H:     return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // One complete access: issue, time the stall, compare at DONE, release.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] mtype, input bit sign,
                           input logic [31:0] exp_rdata, input bit exp_mis, input string name);
    exp_t e;
    int   cyc;
    sb.push_back('{rdata: exp_rdata, mis: exp_mis});
    @(posedge clk); #1;
    bus.wmem      = wr;
    bus.rmem      = !wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_type  = mtype;
    bus.mem_sign  = sign;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_issue got %b want 1", name, bus.busy);
    end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != WAIT_CYCLES + 1) begin
      errors++;
      $display("FAIL %s done_cycle got %0d want %0d", name, cyc, WAIT_CYCLES + 1);
    end
    e = sb.pop_front();
    checks++;
    if (bus.mem_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata got %h want %h", name, bus.mem_rdata, e.rdata);
    end
    checks++;
    if (bus.misalign !== e.mis) begin
      errors++;
      $display("FAIL %s misalign got %b want %b", name, bus.misalign, e.mis);
    end
    @(posedge clk); #1;
    bus.wmem = 1'b0;
    bus.rmem = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.misalign !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done busy/misalign got %b%b want 00", name, bus.busy, bus.misalign);
    end
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.rmem      = 1'b0;
    bus.wmem      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_type  = T_W;
    bus.mem_sign  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.misalign !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b mis=%b rdata=%h want 0 0 0",
               bus.busy, bus.misalign, bus.mem_rdata);
    end
    bus.rmem = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_masked got %b want 0", bus.busy);
    end
    bus.rmem = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_word();
    do_access(1'b1, 32'h10, 32'hDEADBEEF, T_W, 1'b0, 32'h0, 1'b0, "word_store");
    do_access(1'b0, 32'h10, 32'h0, T_W, 1'b0, 32'hDEADBEEF, 1'b0, "word_load");
  endtask

  task automatic test_byte();
    do_access(1'b1, 32'h10, 32'h80FF7F01, T_W, 1'b0, 32'h0, 1'b0, "byte_setup");
    do_access(1'b0, 32'h13, 32'h0, T_B, 1'b1, 32'hFFFFFF80, 1'b0, "byte_load_signed");
    do_access(1'b0, 32'h13, 32'h0, T_B, 1'b0, 32'h00000080, 1'b0, "byte_load_zero");
    do_access(1'b0, 32'h11, 32'h0, T_B, 1'b1, 32'h0000007F, 1'b0, "byte_load_pos");
    do_access(1'b1, 32'h12, 32'h000000AB, T_B, 1'b0, 32'h0, 1'b0, "byte_store");
    do_access(1'b0, 32'h10, 32'h0, T_W, 1'b0, 32'h80AB7F01, 1'b0, "byte_store_word");
  endtask

  task automatic test_half();
    do_access(1'b1, 32'h20, 32'h11223344, T_W, 1'b0, 32'h0, 1'b0, "half_setup");
    do_access(1'b1, 32'h22, 32'h0000A5A5, T_H, 1'b0, 32'h0, 1'b0, "half_store");
    do_access(1'b0, 32'h20, 32'h0, T_W, 1'b0, 32'hA5A53344, 1'b0, "half_store_word");
    do_access(1'b0, 32'h22, 32'h0, T_H, 1'b1, 32'hFFFFA5A5, 1'b0, "half_load_signed");
    do_access(1'b0, 32'h22, 32'h0, T_H, 1'b0, 32'h0000A5A5, 1'b0, "half_load_zero");
    do_access(1'b0, 32'h20, 32'h0, T_R, 1'b1, 32'hA5A53344, 1'b0, "reserved_as_word");
    do_access(1'b1, 32'h1020, 32'hCAFE0000, T_W, 1'b0, 32'h0, 1'b0, "wrap_store");
    do_access(1'b0, 32'h20, 32'h0, T_W, 1'b0, 32'hCAFE0000, 1'b0, "wrap_load");
    do_access(1'b0, 32'hFFFFF020, 32'h0, T_W, 1'b1, 32'hCAFE0000, 1'b0, "wrap_high_load");
  endtask

  task automatic test_both_strobes();
    sb.push_back('{rdata: 32'h0, mis: 1'b0});
    @(posedge clk); #1;
    bus.rmem = 1'b1; bus.wmem = 1'b1;
    bus.mem_addr = 32'h30; bus.mem_wdata = 32'h5A5A0F0F; bus.mem_type = T_W;
    repeat (WAIT_CYCLES + 1) @(posedge clk);
    @(negedge clk);
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_rdata !== e.rdata) begin
        errors++;
        $display("FAIL both_strobes busy=%b rdata got %h want 0 %h", bus.busy, bus.mem_rdata, e.rdata);
      end
    end
    bus.rmem = 1'b0; bus.wmem = 1'b0;
    do_access(1'b0, 32'h30, 32'h0, T_W, 1'b0, 32'h5A5A0F0F, 1'b0, "both_strobes_load");
  endtask

  task automatic test_abort();
    do_access(1'b1, 32'h40, 32'h0BADF00D, T_W, 1'b0, 32'h0, 1'b0, "abort_pre_store");
    do_access(1'b0, 32'h40, 32'h0, T_W, 1'b0, 32'h0BADF00D, 1'b0, "abort_pre_load");
    @(posedge clk); #1;
    bus.wmem = 1'b1; bus.rmem = 1'b0;
    bus.mem_addr = 32'h40; bus.mem_wdata = 32'h12345678; bus.mem_type = T_W;
    @(posedge clk); #1;
    bus.wmem = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait_busy got %b want 1", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.mem_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL abort_rdata_kept got %h want %h", bus.mem_rdata, 32'h0BADF00D);
    end
    do_access(1'b0, 32'h40, 32'h0, T_W, 1'b0, 32'h0BADF00D, 1'b0, "abort_no_write");
  endtask

  task automatic test_reset_mid();
    do_access(1'b1, 32'h04, 32'h11111111, T_W, 1'b0, 32'h0, 1'b0, "rst_pre_store");
    do_access(1'b0, 32'h04, 32'h0, T_W, 1'b0, 32'h11111111, 1'b0, "rst_pre_load");
    @(posedge clk); #1;
    bus.wmem = 1'b1; bus.rmem = 1'b0;
    bus.mem_addr = 32'h04; bus.mem_wdata = 32'h99999999; bus.mem_type = T_W;
    repeat (WAIT_CYCLES) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async got busy=%b rdata=%h want 0 00000000", bus.busy, bus.mem_rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.wmem = 1'b0;
    do_access(1'b0, 32'h04, 32'h0, T_W, 1'b0, 32'h11111111, 1'b0, "rst_no_write");
  endtask

  task automatic test_misalign();
    do_access(1'b1, 32'h04, 32'h01020304, T_W, 1'b0, 32'h0, 1'b0, "mis_setup");
`ifdef DMEM_MISALIGN_TRAP_EN
    do_access(1'b1, 32'h06, 32'h55667788, T_W, 1'b0, 32'h0, 1'b1, "mis_store_trap");
    do_access(1'b0, 32'h04, 32'h0, T_W, 1'b0, 32'h01020304, 1'b0, "mis_store_suppressed");
    do_access(1'b0, 32'h06, 32'h0, T_W, 1'b0, 32'h0, 1'b1, "mis_load_trap");
    do_access(1'b0, 32'h05, 32'h0, T_H, 1'b1, 32'h0, 1'b1, "mis_half_trap");
`else
    do_access(1'b1, 32'h06, 32'h55667788, T_W, 1'b0, 32'h0, 1'b0, "mis_store_aligned");
    do_access(1'b0, 32'h04, 32'h0, T_W, 1'b0, 32'h55667788, 1'b0, "mis_store_hit");
    do_access(1'b0, 32'h06, 32'h0, T_W, 1'b0, 32'h55667788, 1'b0, "mis_load_aligned");
    do_access(1'b0, 32'h05, 32'h0, T_H, 1'b1, 32'h00007788, 1'b0, "mis_half_aligned");
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] pattern;
    exp_t       e;
    pattern = 8'b0111_0111;
    sb.push_back('{rdata: 32'h80AB7F01, mis: 1'b0});
    sb.push_back('{rdata: 32'hCAFE0000, mis: 1'b0});
    @(posedge clk); #1;
    bus.rmem = 1'b1; bus.wmem = 1'b0;
    bus.mem_addr = 32'h10; bus.mem_type = T_W; bus.mem_sign = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== pattern[c]) begin
        errors++;
        $display("FAIL b2b_busy_c%0d got %b want %b", c, bus.busy, pattern[c]);
      end
      if (c == 3 || c == 7) begin
        e = sb.pop_front();
        checks++;
        if (bus.mem_rdata !== e.rdata) begin
          errors++;
          $display("FAIL b2b_rdata_c%0d got %h want %h", c, bus.mem_rdata, e.rdata);
        end
        if (c == 3) bus.mem_addr = 32'h20;
        else        bus.rmem = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] model_w[6];
    logic [1:0]  t;
    logic [1:0]  off;
    bit          s;
    int          k;
    for (int i = 0; i < 6; i++) begin
      model_w[i] = $urandom;
      do_access(1'b1, 32'h200 + 32'(4 * i), model_w[i], T_W, 1'b0, 32'h0, 1'b0, "rnd_store");
    end
    for (int n = 0; n < 12; n++) begin
      k   = $urandom_range(0, 5);
      t   = 2'($urandom_range(0, 3));
      s   = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      if (t == T_H) off[0] = 1'b0;
      if (t == T_W || t == T_R) off = 2'b00;
      do_access(1'b0, 32'h200 + 32'(4 * k) + 32'(off), 32'h0, t, s,
                extract(model_w[k], off, t, s), 1'b0, "rnd_load");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_both_strobes();
    test_abort();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
